// File: rtl/formant_dp_sweep.sv
// DP sweep engine for formant tracking: for frame i computes F(k,i) = min_j E(j+1,i) + F(k-1,j)
// and backpointer B(k,i) for k = 1..min(FORMANTS, i+1), one table read request per cycle.
module formant_dp_sweep #(
  parameter int unsigned BIT_WIDTH    = 32,
  parameter int unsigned I            = 160,
  parameter int unsigned FORMANTS     = 5,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned IW = $clog2(I),
  localparam int unsigned JW = $clog2(I) + 1,
  localparam int unsigned KW = $clog2(FORMANTS + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic [IW-1:0]        i_in,
  input  logic                 accum_in,
  input  logic                 abort_in,
  output logic                 ready_out,
  output logic                 req_valid_out,
  output logic [KW-1:0]        k_req_out,
  output logic [JW-1:0]        j_req_out,
  input  logic [BIT_WIDTH-1:0] e_in,
  input  logic [BIT_WIDTH-1:0] f_prev_in,
  input  logic [BIT_WIDTH-1:0] f_old_in,
  output logic                 write_valid_out,
  output logic [KW-1:0]        k_write_out,
  output logic [BIT_WIDTH-1:0] f_data_out,
  output logic [JW-1:0]        b_data_out,
  output logic                 b_update_out,
  output logic                 done_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [BIT_WIDTH-1:0] MAX = '1;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [KW-1:0] k;
    logic [JW-1:0] j;
  } tag_t;

  logic [1:0]           state, state_nxt;
  logic [IW-1:0]        i_r;
  logic                 accum_r;
  logic [KW-1:0]        kmax_r, kmax_in;
  logic [KW-1:0]        k_cur, k_nxt;
  logic [JW-1:0]        j_cur, j_nxt;
  logic [JW-1:0]        j_last;
  logic                 accept, abort_act;
  tag_t                 req_nxt;
  tag_t                 pipe [0:READ_LATENCY];
  tag_t                 dv;
  logic [BIT_WIDTH:0]   sum;
  logic [BIT_WIDTH-1:0] cand, seed_f, new_f, best_r;
  logic [JW-1:0]        seed_b, new_b, b_r;
  logic                 seed_u, new_u, upd_r;

  assign ready_out     = (state == S_IDLE);
  assign req_valid_out = pipe[0].valid;
  assign k_req_out     = pipe[0].k;
  assign j_req_out     = pipe[0].j;

  assign kmax_in   = (32'(i_in) + 32'd1 < FORMANTS) ? KW'(32'(i_in) + 32'd1) : KW'(FORMANTS);
  assign j_last    = {1'b0, i_r} - JW'(1);
  assign abort_act = abort_in && (state != S_IDLE);

  // The accepting edge already registers the single k=1 request, so SWEEP starts at k=2.
  always_comb begin
    state_nxt = state;
    k_nxt     = k_cur;
    j_nxt     = j_cur;
    req_nxt   = '0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_in && (32'(i_in) < I)) begin
          accept        = 1'b1;
          req_nxt.valid = 1'b1;
          req_nxt.first = 1'b1;
          req_nxt.last  = 1'b1;
          req_nxt.k     = KW'(1);
          req_nxt.j     = '1;
          k_nxt         = KW'(2);
          j_nxt         = '0;
          state_nxt     = (kmax_in == KW'(1)) ? S_DRAIN : S_SWEEP;
        end
      end
      S_SWEEP: begin
        req_nxt.valid = 1'b1;
        req_nxt.first = (j_cur == JW'(k_cur) - JW'(2));
        req_nxt.last  = (j_cur == j_last);
        req_nxt.k     = k_cur;
        req_nxt.j     = j_cur;
        if (j_cur == j_last) begin
          if (k_cur == kmax_r) begin
            state_nxt = S_DRAIN;
          end else begin
            k_nxt = k_cur + KW'(1);
            j_nxt = JW'(k_cur) - JW'(1);
          end
        end else begin
          j_nxt = j_cur + JW'(1);
        end
      end
      S_DRAIN: begin
        if (done_out) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_act) begin
      state_nxt = S_IDLE;
      req_nxt   = '0;
    end
  end

  // Data stage: the tag delayed READ_LATENCY cycles lines up with the returned table words.
  always_comb begin
    dv     = pipe[READ_LATENCY];
    sum    = {1'b0, e_in} + {1'b0, f_prev_in};
    cand   = (dv.k == KW'(1)) ? e_in : (sum[BIT_WIDTH] ? MAX : sum[BIT_WIDTH-1:0]);
    seed_f = dv.first ? (accum_r ? f_old_in : MAX) : best_r;
    seed_b = dv.first ? dv.j : b_r;
    seed_u = dv.first ? 1'b0 : upd_r;
    if (cand < seed_f) begin
      new_f = cand;
      new_b = dv.j;
      new_u = 1'b1;
    end else begin
      new_f = seed_f;
      new_b = seed_b;
      new_u = seed_u;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= S_IDLE;
      i_r     <= '0;
      accum_r <= 1'b0;
      kmax_r  <= '0;
      k_cur   <= '0;
      j_cur   <= '0;
      for (int unsigned n = 0; n <= READ_LATENCY; n++) pipe[n] <= '0;
      best_r          <= '0;
      b_r             <= '0;
      upd_r           <= 1'b0;
      write_valid_out <= 1'b0;
      k_write_out     <= '0;
      f_data_out      <= '0;
      b_data_out      <= '0;
      b_update_out    <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      state <= state_nxt;
      k_cur <= k_nxt;
      j_cur <= j_nxt;
      if (accept) begin
        i_r     <= i_in;
        accum_r <= accum_in;
        kmax_r  <= kmax_in;
      end
      pipe[0] <= req_nxt;
      for (int unsigned n = 1; n <= READ_LATENCY; n++) pipe[n] <= abort_act ? '0 : pipe[n-1];
      if (dv.valid) begin
        best_r <= new_f;
        b_r    <= new_b;
        upd_r  <= new_u;
      end
      write_valid_out <= dv.valid && dv.last && !abort_act;
      done_out        <= dv.valid && dv.last && (dv.k == kmax_r) && !abort_act;
      if (dv.valid && dv.last) begin
        k_write_out  <= dv.k;
        f_data_out   <= new_f;
        b_data_out   <= new_b;
        b_update_out <= new_u;
      end
    end
  end

endmodule

// File: tb/tb_formant_dp_sweep.sv
// Self-checking bench for formant_dp_sweep: table vectors from known cases, randomized frames
// against a min-over-j reference model, plus abort and mid-frame reset sequences.
module tb_formant_dp_sweep;

  localparam int BW   = 16;
  localparam int NI   = 8;
  localparam int NF   = 3;
  localparam int RL   = 2;
  localparam int MAXV = 65535;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic [2:0]    i_in;
  logic          accum_in;
  logic          abort_in;
  logic          ready_out;
  logic          req_valid_out;
  logic [1:0]    k_req_out;
  logic [3:0]    j_req_out;
  logic [BW-1:0] e_in;
  logic [BW-1:0] f_prev_in;
  logic [BW-1:0] f_old_in;
  logic          write_valid_out;
  logic [1:0]    k_write_out;
  logic [BW-1:0] f_data_out;
  logic [3:0]    b_data_out;
  logic          b_update_out;
  logic          done_out;

  always #5 clk_in = ~clk_in;

  formant_dp_sweep #(
    .BIT_WIDTH(BW),
    .I(NI),
    .FORMANTS(NF),
    .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .start_in(start_in),
    .i_in(i_in),
    .accum_in(accum_in),
    .abort_in(abort_in),
    .ready_out(ready_out),
    .req_valid_out(req_valid_out),
    .k_req_out(k_req_out),
    .j_req_out(j_req_out),
    .e_in(e_in),
    .f_prev_in(f_prev_in),
    .f_old_in(f_old_in),
    .write_valid_out(write_valid_out),
    .k_write_out(k_write_out),
    .f_data_out(f_data_out),
    .b_data_out(b_data_out),
    .b_update_out(b_update_out),
    .done_out(done_out)
  );

  int tests = 0;
  int fails = 0;

  // Table memories indexed [k][j+1]
  int e_tab  [1:NF][0:NI];
  int fp_tab [1:NF][0:NI];
  int fo_tab [1:NF];

  int got_f [1:NF];
  int got_b [1:NF];
  int got_u [1:NF];
  int got_done;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_random();
    for (int k = 1; k <= NF; k++) begin
      fo_tab[k] = (($urandom % 4) == 0) ? MAXV : int'($urandom % 16);
      for (int j = 0; j <= NI; j++) begin
        e_tab[k][j]  = (($urandom % 4) == 0) ? int'(32'hFF00 + $urandom % 256) : int'($urandom % 16);
        fp_tab[k][j] = (($urandom % 4) == 0) ? int'(32'hFF00 + $urandom % 256) : int'($urandom % 16);
      end
    end
  endtask

  // Reference: best over the candidate set for k, seeded by old F or MAX, earliest j wins ties.
  function automatic void model_k(input int k, input int i, input bit acc,
                                  output int f, output int b, output int u);
    int lo, hi, c;
    lo = (k == 1) ? -1 : k - 2;
    hi = (k == 1) ? -1 : i - 1;
    f  = acc ? fo_tab[k] : MAXV;
    b  = lo;
    u  = 0;
    for (int j = lo; j <= hi; j++) begin
      if (k == 1) c = e_tab[k][j+1];
      else begin
        c = e_tab[k][j+1] + fp_tab[k][j+1];
        if (c > MAXV) c = MAXV;
      end
      if (c < f) begin
        f = c;
        b = j;
        u = 1;
      end
    end
  endfunction

  // Table memory: answers each observed request RL cycles later, junk when no request is due.
  initial begin
    bit hv [0:RL];
    int hk [0:RL];
    int hj [0:RL];
    for (int n = 0; n <= RL; n++) begin
      hv[n] = 1'b0; hk[n] = 0; hj[n] = 0;
    end
    e_in = '0; f_prev_in = '0; f_old_in = '0;
    forever begin
      @(negedge clk_in);
      for (int n = RL; n > 0; n--) begin
        hv[n] = hv[n-1]; hk[n] = hk[n-1]; hj[n] = hj[n-1];
      end
      hv[0] = req_valid_out;
      hk[0] = int'(k_req_out);
      hj[0] = int'($signed(j_req_out));
      if (hv[RL] && hk[RL] >= 1 && hk[RL] <= NF && hj[RL] >= -1 && hj[RL] < NI) begin
        e_in      = BW'(e_tab[hk[RL]][hj[RL]+1]);
        f_prev_in = BW'(fp_tab[hk[RL]][hj[RL]+1]);
        f_old_in  = BW'(fo_tab[hk[RL]]);
      end else begin
        e_in      = BW'($urandom);
        f_prev_in = BW'($urandom);
        f_old_in  = BW'($urandom);
      end
    end
  end

  task automatic run_frame(input int i, input bit acc, input bit noise);
    int kmax, n, nreq, nwr, done_t, ef, eb, eu;
    int cum [0:NF];
    int expk[$];
    int expj[$];
    kmax = (i + 1 < NF) ? i + 1 : NF;
    cum[0] = 0;
    for (int k = 1; k <= NF; k++) begin
      got_f[k] = -1; got_b[k] = -9; got_u[k] = -1;
      cum[k] = cum[k-1];
      if (k <= kmax) begin
        n = (k == 1) ? 1 : i - k + 2;
        for (int m = 0; m < n; m++) begin
          expk.push_back(k);
          expj.push_back((k == 1) ? -1 : k - 2 + m);
        end
        cum[k] = cum[k-1] + n;
      end
    end
    @(negedge clk_in);
    check("ready_before_start", ready_out, 1);
    start_in = 1'b1;
    i_in     = 3'(i);
    accum_in = acc;
    abort_in = noise ? 1'($urandom % 2) : 1'b0;
    nreq = 0; nwr = 0; done_t = -1;
    for (int t = 1; t <= 200 && done_t < 0; t++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      abort_in = 1'b0;
      if (req_valid_out) begin
        if (nreq < expk.size()) begin
          check("req_k", k_req_out, expk[nreq]);
          check("req_j", $signed(j_req_out), expj[nreq]);
          check("req_cycle", t, nreq + 1);
        end else check("req_count_live", nreq + 1, expk.size());
        nreq++;
      end
      if (write_valid_out) begin
        if (nwr < kmax) begin
          model_k(nwr + 1, i, acc, ef, eb, eu);
          check("wr_k", k_write_out, nwr + 1);
          check("wr_cycle", t, cum[nwr+1] + RL + 1);
          check("wr_f", f_data_out, ef);
          check("wr_b", $signed(b_data_out), eb);
          check("wr_upd", b_update_out, eu);
          got_f[nwr+1] = int'(f_data_out);
          got_b[nwr+1] = int'($signed(b_data_out));
          got_u[nwr+1] = int'(b_update_out);
        end else check("write_count_live", nwr + 1, kmax);
        nwr++;
      end
      if (done_out) done_t = t;
      else if (noise) begin
        start_in = 1'($urandom % 2);
        i_in     = 3'($urandom % NI);
        accum_in = 1'($urandom % 2);
      end
    end
    check("done_cycle", done_t, cum[kmax] + RL + 1);
    check("req_total", nreq, cum[kmax]);
    check("write_total", nwr, kmax);
    got_done = done_t;
    @(negedge clk_in);
    check("ready_after_done", ready_out, 1);
    check("write_after_done", write_valid_out, 0);
  endtask

  typedef struct {
    int i; int acc; int k;
    int e0; int e1; int e2;
    int p0; int p1; int p2;
    int fo; int ef; int eb; int eu; int edone;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int ev [3];
    int pv [3];
    int ncand, j;
    bit wr_seen, done_seen;

    vecs[0] = '{0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 5, -1, 1, 4};
    vecs[1] = '{3, 0, 2, 4, 3, 8, 5, 4, 0, 0, 7, 1, 1, 9};
    vecs[2] = '{3, 0, 3, 3, 2, 0, 3, 4, 0, 0, 6, 1, 1, 9};
    vecs[3] = '{1, 0, 2, 32'hFFF0, 0, 0, 32'h0020, 0, 0, 0, 32'hFFFF, 0, 0, 5};
    vecs[4] = '{2, 1, 2, 6, 4, 0, 0, 0, 0, 4, 4, 0, 0, 7};
    vecs[5] = '{2, 1, 2, 6, 3, 0, 0, 0, 0, 4, 3, 1, 1, 7};

    rst_n_in = 1'b0;
    start_in = 1'b0; i_in = '0; accum_in = 1'b0; abort_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_ready", ready_out, 1);
    check("rst_req_valid", req_valid_out, 0);
    check("rst_write_valid", write_valid_out, 0);
    check("rst_done", done_out, 0);
    check("rst_f_data", f_data_out, 0);
    check("rst_b_data", b_data_out, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    for (int v = 0; v < 6; v++) begin
      fill_random();
      ev[0] = vecs[v].e0; ev[1] = vecs[v].e1; ev[2] = vecs[v].e2;
      pv[0] = vecs[v].p0; pv[1] = vecs[v].p1; pv[2] = vecs[v].p2;
      ncand = (vecs[v].k == 1) ? 1 : vecs[v].i - vecs[v].k + 2;
      for (int m = 0; m < ncand; m++) begin
        j = (vecs[v].k == 1) ? -1 : vecs[v].k - 2 + m;
        e_tab[vecs[v].k][j+1]  = ev[m];
        fp_tab[vecs[v].k][j+1] = pv[m];
      end
      fo_tab[vecs[v].k] = vecs[v].fo;
      run_frame(vecs[v].i, 1'(vecs[v].acc), 1'b0);
      check($sformatf("vec%0d_f", v), got_f[vecs[v].k], vecs[v].ef);
      check($sformatf("vec%0d_b", v), got_b[vecs[v].k], vecs[v].eb);
      check($sformatf("vec%0d_upd", v), got_u[vecs[v].k], vecs[v].eu);
      check($sformatf("vec%0d_done", v), got_done, vecs[v].edone);
    end

    repeat (25) begin
      fill_random();
      run_frame(int'($urandom % NI), 1'($urandom % 2), 1'b1);
    end

    // Abort during an i=3 sweep at cycle 3
    fill_random();
    wr_seen = 1'b0; done_seen = 1'b0;
    @(negedge clk_in);
    start_in = 1'b1; i_in = 3'd3; accum_in = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      abort_in = (t == 3);
      if (t == 3) check("abort_busy", ready_out, 0);
      if (t == 4) begin
        check("abort_ready", ready_out, 1);
        check("abort_req_off", req_valid_out, 0);
      end
      wr_seen   = wr_seen | write_valid_out;
      done_seen = done_seen | done_out;
    end
    abort_in = 1'b0;
    check("abort_no_write", wr_seen, 0);
    check("abort_no_done", done_seen, 0);
    fill_random();
    run_frame(3, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a sweep
    fill_random();
    @(negedge clk_in);
    start_in = 1'b1; i_in = 3'd3; accum_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    check("midrst_sweeping", req_valid_out, 1);
    rst_n_in = 1'b0;
    #1;
    check("midrst_ready", ready_out, 1);
    check("midrst_req_valid", req_valid_out, 0);
    check("midrst_k_req", k_req_out, 0);
    check("midrst_j_req", j_req_out, 0);
    check("midrst_write", write_valid_out, 0);
    check("midrst_done", done_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    fill_random();
    e_tab[1][0] = 5;
    run_frame(0, 1'b0, 1'b0);
    check("postrst_f", got_f[1], 5);
    check("postrst_b", got_b[1], -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/formant_dp_sweep.md
# formant_dp_sweep

Parametrised dynamic-programming sweep engine for formant tracking. For one frame index i it computes F(k,i) = min over j of E(j+1,i) + F(k-1,j) and the backpointer B(k,i) for every k in 1..min(FORMANTS, i+1). It issues one table-read request per cycle with a configurable read latency and runs the k sweeps back-to-back. It sits between the E_min/F table memories and the backtrace unit.

## Interface
- BIT_WIDTH, 32, cost width (unsigned)
- I, 160, frames per utterance
- FORMANTS, 5, maximum k
- READ_LATENCY, 2, cycles from request to e_in/f_prev_in/f_old_in valid (>=1)
- JW = $clog2(I)+1 (signed j), KW = $clog2(FORMANTS+1) (derived)

- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- start_in  in  1  begin frame; accepted only when ready_out=1
- i_in  in  $clog2(I)  frame index, sampled on accept
- accum_in  in  1  sampled on accept; 1 = seed each minimum with old F(k,i)
- abort_in  in  1  cancel current frame
- ready_out  out  1  idle, can accept start
- req_valid_out  out  1  request valid
- k_req_out  out  KW  requested k
- j_req_out  out  JW  requested j (signed, may be -1)
- e_in  in  BIT_WIDTH  E(j+1,i), READ_LATENCY after request
- f_prev_in  in  BIT_WIDTH  F(k-1,j), same timing
- f_old_in  in  BIT_WIDTH  F(k,i), same timing
- write_valid_out  out  1  one-cycle pulse, result for k_write_out
- k_write_out  out  KW  k of result
- f_data_out  out  BIT_WIDTH  new F(k,i)
- b_data_out  out  JW  B(k,i), signed j
- b_update_out  out  1  1 if any candidate beat the seed
- done_out  out  1  one-cycle pulse, frame finished

## Operation
- States: IDLE, SWEEP, DRAIN. ready_out=1 only in IDLE.
- IDLE: start_in=1 with i_in<I → latch i, accum, kmax=min(FORMANTS,i+1), go to SWEEP. start_in with i_in>=I is ignored.
- SWEEP: one request per cycle, k ascending. k=1 issues only j=-1. k>=2 issues j=k-2..i-1. The last request of k is followed next cycle by the first request of k+1. After the last request of kmax, go to DRAIN.
- Candidate: for k=1, e_in (f_prev_in ignored). For k>=2, e_in+f_prev_in computed in BIT_WIDTH+1 bits, saturated to 2^BIT_WIDTH-1 (MAX).
- Seed per k, taken alongside the first candidate of k:
  - accum=1 → f_old_in.
  - accum=0 → MAX.
  - b seed = first j of k; b_update cleared.
- Update rule: strict candidate < best → best=candidate, b=j, b_update=1. Ties keep the earliest j. A MAX candidate never updates a MAX seed.
- Result emission: write_valid_out pulses with k_write_out, f_data_out=best, b_data_out, b_update_out.
- DRAIN: wait for in-flight results. done_out pulses with the final write_valid_out, then return to IDLE.
- Pipeline: k/j/first/last/valid tags are carried READ_LATENCY stages, so adjacent k sweeps never mix.
- abort_in=1 in SWEEP/DRAIN: next cycle IDLE. In-flight results are dropped; no write_valid_out, no done_out. abort_in in IDLE has no effect.

## Timing
- Reset: all outputs 0 except ready_out=1. State IDLE, pipeline valids cleared.
- Accept at cycle 0 → first request at cycle 1. Total requests N = 1 + sum over k=2..kmax of (i-k+2).
- A request at cycle t has its data sampled at t+READ_LATENCY. For the last request of k, write_valid_out is at t+READ_LATENCY+1.
- Final write and done_out at cycle N+READ_LATENCY+1; ready_out=1 the cycle after.
- Outputs change only on clock edges. req_valid_out/k_req_out/j_req_out are registered; holding them stable between requests is not required.
- start_in while busy is ignored. start_in and abort_in together in IDLE: start is accepted.
- Reset mid-frame: immediate IDLE, all outputs to reset values.

## Test plan
- BIT_WIDTH=16, I=8, FORMANTS=3, READ_LATENCY=2, i=0, e=5 → one request (1,-1) at cycle 1. Write k=1, f=5, b=-1, b_update=1 with done_out at cycle 4.
- i=3, accum=0: 6 consecutive requests (1,-1),(2,0),(2,1),(2,2),(3,1),(3,2).
  - k=2 candidates 9,7,8 → f=7, b=1.
  - k=3 candidates 6,6 → f=6, b=1 (tie keeps earliest).
  - done_out at cycle 9.
- Saturation: k=2, i=1, e=16'hFFF0, f_prev=16'h0020, accum=0 → f=16'hFFFF, b=0, b_update=0.
- accum=1, f_old=4, k=2 candidates 6,4 → f=4, b_update=0. Rerun with candidates 6,3 → f=3, b=1, b_update=1.
- abort_in asserted at cycle 3 of an i=3 run → no write_valid_out/done_out. ready_out=1 at cycle 4. A new start then completes correctly.
- rst_n_in low at cycle 2 mid-sweep → outputs immediately at reset values. After release, i=0 run passes.
